// File: rtl/controle_portao_param.sv
// Gate/door controller: synchronised inputs, debounced button,
// travel timeout, auto-close, obstacle reversal, stop/resume, sticky fault.
module controle_portao_param #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int MOVE_TIMEOUT = 1000,
   parameter int AUTO_CLOSE   = 500,
   parameter int CNT_W        = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       botao,
   input  logic       fim_aberto,
   input  logic       fim_fechado,
   input  logic       obstaculo,
   output logic       motor_liga,
   output logic       motor_sentido,
   output logic       ledVerde,
   output logic       ledVermelho,
   output logic [6:0] display,
   output logic [2:0] estado_out,
   output logic       falha
);

   typedef enum logic [2:0] {
      FECHADO  = 3'd0,
      ABRINDO  = 3'd1,
      ABERTO   = 3'd2,
      FECHANDO = 3'd3,
      PARADO   = 3'd4,
      FALHA    = 3'd5
   } estado_t;

   localparam int DB_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MOVE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] AC_LAST  = CNT_W'(AUTO_CLOSE - 1);
   localparam bit               AC_EN    = (AUTO_CLOSE != 0);

   estado_t          estado, nxt;
   logic             dir, dir_nxt;
   logic [CNT_W-1:0] timer;
   logic [3:0]       sync1, sync2;
   logic [DB_W-1:0]  db_cnt;
   logic             btn_db, btn_db_q;
   logic             s_btn, s_fa, s_ff, s_obs;
   logic             cmd, contando;

   assign {s_btn, s_fa, s_ff, s_obs} = sync2;
   assign cmd = btn_db & ~btn_db_q;
   assign contando = (estado == ABRINDO) || (estado == FECHANDO) ||
                     (estado == ABERTO);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= '0;
         sync2    <= '0;
         db_cnt   <= '0;
         btn_db   <= 1'b0;
         btn_db_q <= 1'b0;
      end else begin
         sync1    <= {botao, fim_aberto, fim_fechado, obstaculo};
         sync2    <= sync1;
         btn_db_q <= btn_db;
         // level flips only after DEBOUNCE_CYC consecutive differing samples
         if (s_btn == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            btn_db <= s_btn;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado <= FECHADO;
         dir    <= 1'b0;
         timer  <= '0;
      end else begin
         estado <= nxt;
         dir    <= dir_nxt;
         if (nxt != estado)
            timer <= '0;
         else if (estado == ABERTO && s_obs)
            timer <= '0;
         else if (contando && timer != '1)
            timer <= timer + 1'b1;
      end
   end

   always_comb begin
      nxt     = estado;
      dir_nxt = dir;
      if (estado != FALHA && s_fa && s_ff) begin
         nxt = FALHA;
      end else begin
         unique case (estado)
            FECHADO: if (cmd) nxt = ABRINDO;
            ABRINDO: begin
               if (timer == TMO_LAST) nxt = FALHA;
               else if (s_fa)         nxt = ABERTO;
               else if (cmd) begin
                  nxt     = PARADO;
                  dir_nxt = 1'b1;
               end
            end
            ABERTO: begin
               if (!s_obs && (cmd || (AC_EN && timer == AC_LAST)))
                  nxt = FECHANDO;
            end
            FECHANDO: begin
               if (timer == TMO_LAST) nxt = FALHA;
               else if (s_ff)         nxt = FECHADO;
               else if (s_obs)        nxt = ABRINDO;
               else if (cmd) begin
                  nxt     = PARADO;
                  dir_nxt = 1'b0;
               end
            end
            PARADO:  if (cmd) nxt = dir ? FECHANDO : ABRINDO;
            FALHA:   nxt = FALHA;
            default: nxt = FALHA;
         endcase
      end
   end

   always_comb begin
      motor_liga    = 1'b0;
      motor_sentido = 1'b0;
      ledVerde      = 1'b0;
      ledVermelho   = 1'b0;
      falha         = 1'b0;
      display       = 7'b0000110;
      unique case (estado)
         FECHADO: display = 7'b0001110;
         ABRINDO: begin
            display       = 7'b1000000;
            motor_liga    = 1'b1;
            motor_sentido = 1'b1;
            ledVerde      = 1'b1;
         end
         ABERTO:  display = 7'b0001000;
         FECHANDO: begin
            display     = 7'b1000000;
            motor_liga  = 1'b1;
            ledVermelho = 1'b1;
         end
         PARADO:  display = 7'b0001100;
         FALHA: begin
            ledVermelho = 1'b1;
            falha       = 1'b1;
         end
         default: begin
            ledVermelho = 1'b1;
            falha       = 1'b1;
         end
      endcase
   end

   assign estado_out = estado;

endmodule

// File: tb/tb_controle_portao_param.sv
// Directed bench for controle_portao_param with short timer parameters.
module tb_controle_portao_param;

   localparam logic [2:0] S_FECHADO  = 3'd0;
   localparam logic [2:0] S_ABRINDO  = 3'd1;
   localparam logic [2:0] S_ABERTO   = 3'd2;
   localparam logic [2:0] S_FECHANDO = 3'd3;
   localparam logic [2:0] S_PARADO   = 3'd4;
   localparam logic [2:0] S_FALHA    = 3'd5;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       botao = 1'b0;
   logic       fim_aberto = 1'b0;
   logic       fim_fechado = 1'b0;
   logic       obstaculo = 1'b0;
   logic       motor_liga, motor_sentido, ledVerde, ledVermelho, falha;
   logic [6:0] display;
   logic [2:0] estado_out;

   int checks = 0;
   int errors = 0;
   int n;

   controle_portao_param #(
      .DEBOUNCE_CYC(4),
      .MOVE_TIMEOUT(100),
      .AUTO_CLOSE  (20),
      .CNT_W       (16)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .botao        (botao),
      .fim_aberto   (fim_aberto),
      .fim_fechado  (fim_fechado),
      .obstaculo    (obstaculo),
      .motor_liga   (motor_liga),
      .motor_sentido(motor_sentido),
      .ledVerde     (ledVerde),
      .ledVermelho  (ledVermelho),
      .display      (display),
      .estado_out   (estado_out),
      .falha        (falha)
   );

   always #5 clock = ~clock;

   task automatic idle(input int c);
      repeat (c) @(negedge clock);
   endtask

   task automatic wait_state(input logic [2:0] tgt, input int lim,
                             output int cyc);
      bit done;
      cyc  = 0;
      done = 0;
      while (!done && cyc < lim) begin
         @(negedge clock);
         cyc++;
         if (estado_out === tgt) done = 1;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n     = 1'b0;
      botao       = 1'b0;
      fim_aberto  = 1'b0;
      fim_fechado = 1'b0;
      obstaculo   = 1'b0;
      idle(3);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (estado_out !== S_FECHADO || display !== 7'b0001110) begin
         errors++;
         $display("FAIL reset_state: estado=%0d disp=%b want 0 0001110",
                  estado_out, display);
      end
      checks++;
      if ({motor_liga, motor_sentido, ledVerde, ledVermelho, falha} !== 5'b0)
      begin
         errors++;
         $display("FAIL reset_outputs: got %b want 00000",
                  {motor_liga, motor_sentido, ledVerde, ledVermelho, falha});
      end
   endtask

   task automatic test_open();
      botao = 1'b1;
      wait_state(S_ABRINDO, 30, n);
      checks++;
      if (n !== 7) begin
         errors++;
         $display("FAIL open_latency: got %0d want 7", n);
      end
      checks++;
      if ({motor_liga, motor_sentido, ledVerde} !== 3'b111 ||
          display !== 7'b1000000) begin
         errors++;
         $display("FAIL abrindo_outputs: got %b %b want 111 1000000",
                  {motor_liga, motor_sentido, ledVerde}, display);
      end
      idle(3);
      botao = 1'b0;
      idle(37);
      checks++;
      if (estado_out !== S_ABRINDO) begin
         errors++;
         $display("FAIL still_abrindo: got %0d want 1", estado_out);
      end
      fim_aberto = 1'b1;
      wait_state(S_ABERTO, 10, n);
      checks++;
      if (n !== 3 || display !== 7'b0001000 || motor_liga !== 1'b0) begin
         errors++;
         $display("FAIL aberto_entry: lat=%0d disp=%b motor=%b want 3 0001000 0",
                  n, display, motor_liga);
      end
   endtask

   task automatic test_auto_close();
      wait_state(S_FECHANDO, 40, n);
      checks++;
      if (n !== 20) begin
         errors++;
         $display("FAIL auto_close_time: got %0d want 20", n);
      end
      checks++;
      if ({motor_liga, motor_sentido, ledVermelho} !== 3'b101) begin
         errors++;
         $display("FAIL fechando_outputs: got %b want 101",
                  {motor_liga, motor_sentido, ledVermelho});
      end
      fim_aberto  = 1'b0;
      idle(4);
      fim_fechado = 1'b1;
      wait_state(S_FECHADO, 10, n);
      checks++;
      if (n !== 3 || display !== 7'b0001110) begin
         errors++;
         $display("FAIL close_done: lat=%0d disp=%b want 3 0001110", n, display);
      end
   endtask

   task automatic test_obstacle();
      fim_fechado = 1'b0;
      idle(3);
      botao = 1'b1;
      wait_state(S_ABRINDO, 30, n);
      botao = 1'b0;
      idle(8);
      fim_aberto = 1'b1;
      wait_state(S_ABERTO, 10, n);
      wait_state(S_FECHANDO, 40, n);
      fim_aberto = 1'b0;
      idle(5);
      obstaculo = 1'b1;
      wait_state(S_ABRINDO, 10, n);
      checks++;
      if (n !== 3 || motor_sentido !== 1'b1) begin
         errors++;
         $display("FAIL obstacle_reverse: lat=%0d sentido=%b want 3 1",
                  n, motor_sentido);
      end
   endtask

   task automatic test_timeout();
      obstaculo = 1'b0;
      wait_state(S_FALHA, 200, n);
      checks++;
      if (n !== 100) begin
         errors++;
         $display("FAIL move_timeout: got %0d want 100", n);
      end
      checks++;
      if (falha !== 1'b1 || motor_liga !== 1'b0 || display !== 7'b0000110) begin
         errors++;
         $display("FAIL falha_outputs: falha=%b motor=%b disp=%b want 1 0 0000110",
                  falha, motor_liga, display);
      end
      botao = 1'b1;
      idle(20);
      botao = 1'b0;
      idle(10);
      checks++;
      if (estado_out !== S_FALHA) begin
         errors++;
         $display("FAIL falha_sticky: got %0d want 5", estado_out);
      end
   endtask

   task automatic test_debounce_stop();
      do_reset();
      botao = 1'b1;
      idle(2);
      botao = 1'b0;
      idle(15);
      checks++;
      if (estado_out !== S_FECHADO) begin
         errors++;
         $display("FAIL glitch_ignored: got %0d want 0", estado_out);
      end
      botao = 1'b1;
      wait_state(S_ABRINDO, 30, n);
      botao = 1'b0;
      idle(8);
      botao = 1'b1;
      wait_state(S_PARADO, 30, n);
      botao = 1'b0;
      checks++;
      if (n !== 7 || motor_liga !== 1'b0 || display !== 7'b0001100) begin
         errors++;
         $display("FAIL stop_opening: lat=%0d motor=%b disp=%b want 7 0 0001100",
                  n, motor_liga, display);
      end
      idle(8);
      botao = 1'b1;
      wait_state(S_FECHANDO, 30, n);
      botao = 1'b0;
      checks++;
      if (n !== 7 || motor_sentido !== 1'b0) begin
         errors++;
         $display("FAIL resume_close: lat=%0d sentido=%b want 7 0",
                  n, motor_sentido);
      end
      idle(8);
      botao = 1'b1;
      wait_state(S_PARADO, 30, n);
      botao = 1'b0;
      checks++;
      if (n !== 7 || motor_liga !== 1'b0) begin
         errors++;
         $display("FAIL stop_closing: lat=%0d motor=%b want 7 0", n, motor_liga);
      end
   endtask

   task automatic test_reset_mid_motion();
      do_reset();
      botao = 1'b1;
      wait_state(S_ABRINDO, 30, n);
      botao = 1'b0;
      idle(3);
      reset_n = 1'b0;
      #1;
      checks++;
      if (motor_liga !== 1'b0 || estado_out !== S_FECHADO) begin
         errors++;
         $display("FAIL async_reset: motor=%b estado=%0d want 0 0",
                  motor_liga, estado_out);
      end
      idle(2);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_limit_fault();
      do_reset();
      fim_aberto  = 1'b1;
      fim_fechado = 1'b1;
      wait_state(S_FALHA, 10, n);
      checks++;
      if (n !== 3 || display !== 7'b0000110 || falha !== 1'b1) begin
         errors++;
         $display("FAIL both_limits: lat=%0d disp=%b falha=%b want 3 0000110 1",
                  n, display, falha);
      end
      fim_aberto  = 1'b0;
      fim_fechado = 1'b0;
      do_reset();
      checks++;
      if (estado_out !== S_FECHADO || falha !== 1'b0) begin
         errors++;
         $display("FAIL fault_cleared: estado=%0d falha=%b want 0 0",
                  estado_out, falha);
      end
   endtask

   initial begin
      test_reset();
      test_open();
      test_auto_close();
      test_obstacle();
      test_timeout();
      test_debounce_stop();
      test_reset_mid_motion();
      test_limit_fault();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
